sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Control FSM for one SHA-256 compression of a 512-bit block. It sequences message-word loading, working-variable initialisation, the round loop and the final hash update. It drives the datapath's load/step enables and the external 6-bit round counter (reset/enable in, count back). It sits between the message-block source and the SHA-256 datapath, and supports multi-block messages by selecting IV or chained hash per block.

## Interface
Parameters:
- NUM_ROUNDS, 64, rounds per block; legal range 17..64. The last round index is NUM_ROUNDS-1.
- MSG_WORDS, 16, 32-bit message words accepted per block. Fixed at 16 for SHA-256; kept as a parameter for test builds.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and every output to its reset value.
- start  in  1  request a block compression; sampled only in IDLE.
- first_blk  in  1  qualifies start; 1 means load IV into H, 0 means chain the previous H.
- w_valid  in  1  message word present on the datapath input bus.
- w_ready  out  1  controller accepts a word this cycle (LOAD state).
- w_load  out  1  write the current word into schedule slot w_idx; equals w_valid & w_ready.
- w_idx  out  4  slot index of the word being accepted, 0..15.
- round  in  6  current round count from the external counter.
- cnt_rst  out  1  synchronous clear of the round counter.
- cnt_en  out  1  round counter increment enable.
- init_iv  out  1  load the SHA-256 IV into H0..H7.
- load_vars  out  1  load a..h from H0..H7.
- round_en  out  1  perform one compression round at index round.
- sched_sel  out  1  0 means use stored W[round]; 1 means use the expanded schedule word (round >= 16).
- hash_upd  out  1  H_i <= H_i + working var (mod 2^32).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the block's H is updated.
- digest_valid  out  1  H holds a completed digest; held until the next accepted start.

## Operation
- States: IDLE, LOAD, INIT, ROUND, UPDATE, DONE.
- IDLE:
  - cnt_rst=1.
  - On start: go to LOAD, clear w_idx to 0, clear digest_valid.
  - init_iv = start & first_blk (Mealy, IDLE only).
- LOAD:
  - w_ready=1.
  - Each w_valid cycle accepts one word: w_load=1, w_idx increments.
  - The 16th accepted word (w_idx==15) moves to INIT.
  - w_valid low stalls indefinitely; there is no timeout.
- INIT: one cycle. load_vars=1, cnt_rst=1. Next state is ROUND.
- ROUND:
  - round_en=1, cnt_en=1, sched_sel=(round>=16).
  - When round==NUM_ROUNDS-1, move to UPDATE.
  - The counter may wrap 63->0 during UPDATE; this is harmless.
- UPDATE: one cycle. hash_upd=1. Next state is DONE.
- DONE: one cycle. done=1, digest_valid set. Next state is IDLE.
- start outside IDLE is ignored, with no queuing. first_blk is sampled only together with an accepted start.
- w_valid outside LOAD is ignored: w_load=0 and w_idx holds.
- All outputs except init_iv and w_load are Moore, decoded from state and round.

## Timing
- Reset values: state IDLE, w_ready=0, w_load=0, w_idx=0, cnt_rst=1, cnt_en=0, init_iv=0, load_vars=0, round_en=0, sched_sel=0, hash_upd=0, busy=0, done=0, digest_valid=0.
- Reset mid-operation: return to IDLE on the next edge. The partial block is discarded and digest_valid=0.
- Latency with start at cycle 0 and w_valid held high:
  - LOAD in cycles 1..16.
  - INIT at cycle 17.
  - ROUND in cycles 18..(17+NUM_ROUNDS), with round 0..NUM_ROUNDS-1.
  - UPDATE at cycle 18+NUM_ROUNDS.
  - done at cycle 19+NUM_ROUNDS (83 for the default).
  - IDLE from cycle 20+NUM_ROUNDS.
- Each LOAD cycle with w_valid=0 adds one cycle of latency.
- Back-to-back blocks: the earliest next start is the first IDLE cycle, giving 84 cycles per block at the default.
- round equals 0 in the first ROUND cycle because of the cnt_rst asserted in INIT.

## Test plan
- Reset, then idle 5 cycles: all outputs at reset values, cnt_rst=1, busy=0.
- start=1, first_blk=1, w_valid held high:
  - init_iv pulses at cycle 0.
  - w_load fires 16 times with w_idx 0..15.
  - load_vars at cycle 17.
  - round_en for 64 cycles, with sched_sel=0 for rounds 0..15 and 1 for rounds 16..63.
  - hash_upd at cycle 82, done at cycle 83, digest_valid=1 afterward.
- w_valid toggled 1/0 during LOAD: exactly 16 w_load pulses, w_idx increments only on accepts, done at cycle 83+15.
- Second block with first_blk=0 right after DONE: init_iv stays 0, digest_valid drops on start, done recurs 84 cycles later.
- start pulsed during ROUND (round=30): ignored, no state change, done timing unchanged. A reset asserted at round=40 gives IDLE next cycle with digest_valid=0.
- Checking the hash value: with the datapath and counter attached, the message "abc" (single padded block) yields digest ba7816bf…f20015ad.

Source files
------------

// File: rtl/sha256_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round_ctrl_if
// Description : Handshake, counter and datapath-control bundle for the
//               SHA-256 round controller.
// Revision    : 1.0
// ============================================================================
interface sha256_round_ctrl_if;
    logic       start;
    logic       first_blk;
    logic       w_valid;
    logic       w_ready;
    logic       w_load;
    logic [3:0] w_idx;
    logic [5:0] round;
    logic       cnt_rst;
    logic       cnt_en;
    logic       init_iv;
    logic       load_vars;
    logic       round_en;
    logic       sched_sel;
    logic       hash_upd;
    logic       busy;
    logic       done;
    logic       digest_valid;

    modport master (
        input  start, first_blk, w_valid, round,
        output w_ready, w_load, w_idx, cnt_rst, cnt_en, init_iv, load_vars,
               round_en, sched_sel, hash_upd, busy, done, digest_valid
    );

    modport slave (
        output start, first_blk, w_valid, round,
        input  w_ready, w_load, w_idx, cnt_rst, cnt_en, init_iv, load_vars,
               round_en, sched_sel, hash_upd, busy, done, digest_valid
    );
endinterface
`default_nettype wire

// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round_ctrl
// Description : Control FSM for one SHA-256 block compression (load, init,
//               round loop, hash update) driving an external round counter.
// Revision    : 1.0
// ============================================================================
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int MSG_WORDS  = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sha256_round_ctrl_if.master bus
);

    localparam logic [5:0] C_LAST_ROUND = 6'(NUM_ROUNDS - 1);
    localparam logic [3:0] C_LAST_WORD  = 4'(MSG_WORDS - 1);
    localparam logic [5:0] C_SCHED_FROM = 6'd16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_INIT   = 3'd2,
        S_ROUND  = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] w_idx_q, w_idx_d;
    logic       digest_valid_q, digest_valid_d;
    logic       accept_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            w_idx_q        <= 4'd0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            w_idx_q        <= w_idx_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        w_idx_d        = w_idx_q;
        digest_valid_d = digest_valid_q;
        accept_w       = 1'b0;

        bus.w_ready    = 1'b0;
        bus.cnt_rst    = 1'b0;
        bus.cnt_en     = 1'b0;
        bus.init_iv    = 1'b0;
        bus.load_vars  = 1'b0;
        bus.round_en   = 1'b0;
        bus.sched_sel  = 1'b0;
        bus.hash_upd   = 1'b0;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.cnt_rst = 1'b1;
                // Mealy: the IV load coincides with the accepted start cycle.
                bus.init_iv = bus.start & bus.first_blk & ~reset;
                if (bus.start) begin
                    state_d        = S_LOAD;
                    w_idx_d        = 4'd0;
                    digest_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                bus.w_ready = 1'b1;
                accept_w    = bus.w_valid & ~reset;
                if (bus.w_valid) begin
                    w_idx_d = w_idx_q + 4'd1;
                    if (w_idx_q == C_LAST_WORD) begin
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                bus.load_vars = 1'b1;
                bus.cnt_rst   = 1'b1;
                state_d       = S_ROUND;
            end
            S_ROUND: begin
                bus.round_en  = 1'b1;
                bus.cnt_en    = 1'b1;
                bus.sched_sel = (bus.round >= C_SCHED_FROM);
                if (bus.round == C_LAST_ROUND) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                bus.hash_upd   = 1'b1;
                digest_valid_d = 1'b1;
                state_d        = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.w_load       = accept_w;
    assign bus.w_idx        = w_idx_q;
    assign bus.digest_valid = digest_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_round_ctrl
// Description : Randomized bench with a phase-based reference model and an
//               emulated external round counter.
// Revision    : 1.0
// ============================================================================
module tb_sha256_round_ctrl;

    localparam int NUM_ROUNDS = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    sha256_round_ctrl_if bus();

    sha256_round_ctrl #(.NUM_ROUNDS(NUM_ROUNDS), .MSG_WORDS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External 6-bit round counter as the datapath would provide it.
    initial bus.round = 6'd0;
    always @(posedge clk) begin
        if (reset || bus.cnt_rst) bus.round <= 6'd0;
        else if (bus.cnt_en)      bus.round <= bus.round + 6'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: a block is "active" after an accepted start; acc counts words
    // taken; p counts cycles after the last word (0=init, 1..N=rounds,
    // N+1=hash update, N+2=done).
    bit m_active = 1'b0;
    int m_acc    = 0;
    int m_p      = 0;
    bit m_dv     = 1'b0;

    int done_cyc = -1;
    int wl_cnt   = 0;
    int iv_cnt   = 0;

    always @(negedge clk) begin
        int e_ready, e_load, e_rst, e_en, e_iv, e_lv, e_ren, e_sel, e_hu, e_busy, e_done;
        if (!reset) begin
            e_ready = 0; e_load = 0; e_rst = 0; e_en = 0; e_iv = 0; e_lv = 0;
            e_ren = 0; e_sel = 0; e_hu = 0; e_busy = 1; e_done = 0;
            if (!m_active) begin
                e_busy = 0;
                e_rst  = 1;
                e_iv   = int'(bus.start & bus.first_blk);
            end else if (m_acc < 16) begin
                e_ready = 1;
                e_load  = int'(bus.w_valid);
            end else if (m_p == 0) begin
                e_lv  = 1;
                e_rst = 1;
            end else if (m_p <= NUM_ROUNDS) begin
                e_ren = 1;
                e_en  = 1;
                e_sel = int'((m_p - 1) >= 16);
                chk("round_index", int'(bus.round), m_p - 1);
            end else if (m_p == NUM_ROUNDS + 1) begin
                e_hu = 1;
            end else begin
                e_done = 1;
            end
            chk("w_ready",      int'(bus.w_ready),      e_ready);
            chk("w_load",       int'(bus.w_load),       e_load);
            chk("w_idx",        int'(bus.w_idx),        m_acc % 16);
            chk("cnt_rst",      int'(bus.cnt_rst),      e_rst);
            chk("cnt_en",       int'(bus.cnt_en),       e_en);
            chk("init_iv",      int'(bus.init_iv),      e_iv);
            chk("load_vars",    int'(bus.load_vars),    e_lv);
            chk("round_en",     int'(bus.round_en),     e_ren);
            chk("sched_sel",    int'(bus.sched_sel),    e_sel);
            chk("hash_upd",     int'(bus.hash_upd),     e_hu);
            chk("busy",         int'(bus.busy),         e_busy);
            chk("done",         int'(bus.done),         e_done);
            chk("digest_valid", int'(bus.digest_valid), int'(m_dv));
            if (bus.done)    done_cyc = cyc;
            if (bus.w_load)  wl_cnt++;
            if (bus.init_iv) iv_cnt++;
        end
        // advance the model to the next cycle
        if (reset) begin
            m_active = 1'b0; m_acc = 0; m_p = 0; m_dv = 1'b0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active = 1'b1; m_acc = 0; m_dv = 1'b0;
            end
        end else if (m_acc < 16) begin
            if (bus.w_valid) begin
                m_acc++;
                if (m_acc == 16) m_p = 0;
            end
        end else if (m_p == NUM_ROUNDS + 2) begin
            m_active = 1'b0;
        end else begin
            if (m_p == NUM_ROUNDS + 1) m_dv = 1'b1;
            m_p++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 w_valid high, 1 toggled, 2 random + stray starts,
    //       3 stray start at round 30, 4 reset at round 40
    task automatic run_block(input logic fb, input int mode, output int lat);
        int  s;
        bit  tog;
        bit  pulsed;
        bit  did_reset;
        tog = 1'b1; pulsed = 1'b0; did_reset = 1'b0;
        wl_cnt = 0; iv_cnt = 0;
        s = cyc;
        bus.start = 1'b1; bus.first_blk = fb; bus.w_valid = 1'($urandom % 2);
        tick;
        bus.start = 1'b0; bus.first_blk = 1'($urandom % 2);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            bus.start = 1'b0;
            case (mode)
                1: begin bus.w_valid = tog; tog = ~tog; end
                2: begin
                    bus.w_valid = 1'($urandom % 2);
                    bus.start   = m_active && ($urandom % 12 == 0);
                end
                3: begin
                    bus.w_valid = 1'b1;
                    if (bus.round == 6'd30 && m_active && m_acc == 16 && !pulsed) begin
                        bus.start = 1'b1; pulsed = 1'b1;
                    end
                end
                4: begin
                    bus.w_valid = 1'b1;
                    if (bus.round == 6'd40 && m_active && m_acc == 16) begin
                        reset = 1'b1; did_reset = 1'b1;
                    end
                end
                default: bus.w_valid = 1'b1;
            endcase
            tick;
            if (did_reset) begin
                reset = 1'b0;
                lat = -2;
                break;
            end
            if (done_cyc > s) begin
                lat = done_cyc - s;
                break;
            end
        end
        bus.start = 1'b0;
        bus.w_valid = 1'b0;
        if (lat == -1) chk("block_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        int prev_done;
        bus.start = 1'b0; bus.first_blk = 1'b0; bus.w_valid = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        repeat (5) tick;
        chk("idle_cnt_rst", int'(bus.cnt_rst), 1);
        chk("idle_busy",    int'(bus.busy),    0);

        run_block(1'b1, 0, lat);
        chk("lat_first_block", lat, 83);
        chk("wload_pulses",    wl_cnt, 16);
        chk("init_iv_pulses",  iv_cnt, 1);
        chk("dv_after_done",   int'(bus.digest_valid), 1);
        prev_done = done_cyc;

        run_block(1'b0, 0, lat);
        chk("back_to_back_spacing", done_cyc - prev_done, 84);
        chk("chain_no_init_iv",     iv_cnt, 0);

        repeat (2) tick;
        run_block(1'b1, 1, lat);
        chk("lat_toggled_wvalid", lat, 98);
        chk("wload_pulses_tog",   wl_cnt, 16);

        run_block(1'b0, 3, lat);
        chk("lat_stray_start", lat, 83);

        run_block(1'b1, 4, lat);
        chk("reset_mid_busy", int'(bus.busy), 0);
        chk("reset_mid_dv",   int'(bus.digest_valid), 0);
        chk("reset_mid_cnt_rst", int'(bus.cnt_rst), 1);
        tick;

        for (int b = 0; b < 8; b++) begin
            repeat ($urandom_range(0, 3)) tick;
            run_block(1'($urandom % 2), 2, lat);
            chk("rand_wload_pulses", wl_cnt, 16);
        end
        repeat (3) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
